// File: rtl/uart_frame_rx_pkg.sv
// rtl/uart_frame_rx_pkg.sv - shared constants, state types and frame helpers for the frame receiver
package uart_frame_rx_pkg;

    localparam logic [1:0] HDR         = 2'b10;
    localparam logic [1:0] TAIL        = 2'b11;
    localparam logic       DATA_MSB    = 1'b0;
    localparam int         FRAME_BYTES = 6;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_DATA = 2'd1,
        F_TAIL = 2'd2
    } frame_state_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_START = 2'd1,
        B_BITS  = 2'd2,
        B_STOP  = 2'd3
    } byte_state_t;

    typedef logic [3:0][6:0] slots_t;

    // Each slot carries the low 7 bits of one data byte; the tail supplies the four MSBs.
    function automatic logic [31:0] assemble_data(input slots_t slots, input logic [3:0] msbs);
        return {msbs[3], slots[0], msbs[2], slots[1], msbs[1], slots[2], msbs[0], slots[3]};
    endfunction

    function automatic logic frame_parity(input slots_t slots, input logic tail_lsb);
        return ^{slots[0][0], slots[1][0], slots[2][0], slots[3][0], tail_lsb};
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// rtl/uart_frame_rx_if.sv - serial input and decoded frame outputs of the frame receiver
interface uart_frame_rx_if;

    logic        rx;
    logic        frame_valid;
    logic [4:0]  addr;
    logic [1:0]  kind;
    logic [31:0] data;
    logic        parity_err;
    logic        frame_err;

    modport master (
        output rx,
        input  frame_valid, addr, kind, data, parity_err, frame_err
    );

    modport slave (
        input  rx,
        output frame_valid, addr, kind, data, parity_err, frame_err
    );

endinterface

// File: rtl/uart_frame_rx_byte_rx.sv
// rtl/uart_frame_rx_byte_rx.sv - 8N1 UART byte receiver with start re-check and stop-bit validation
module uart_byte_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic       byte_err,
    output logic [7:0] byte_data
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    byte_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic          r_byte_err;
    logic [7:0]    r_byte_data;
    logic          w_rx;

    assign w_rx       = r_sync[1];
    assign byte_valid = r_byte_valid;
    assign byte_err   = r_byte_err;
    assign byte_data  = r_byte_data;

    // Starts are armed only by a true high-to-low edge, so a low stop bit cannot retrigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync       <= 2'b11;
            r_prev       <= 1'b1;
            r_state      <= B_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
            r_byte_data  <= '0;
        end else begin
            r_sync       <= {r_sync[0], rx};
            r_prev       <= w_rx;
            r_byte_valid <= 1'b0;
            r_byte_err   <= 1'b0;
            case (r_state)
                B_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (r_prev && !w_rx) r_state <= B_START;
                end
                B_START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_rx ? B_IDLE : B_BITS;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_BITS: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= B_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_STOP: begin
                    if (r_cnt == FULL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= B_IDLE;
                        if (w_rx) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                        end else begin
                            r_byte_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// rtl/uart_frame_rx.sv - reassembles 6-byte UART frames, checks header parity, times out stalled frames
module uart_frame_rx
    import uart_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_CLKS = 52080
) (
    input  logic            clk,
    input  logic            reset,
    uart_frame_rx_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CLKS);
    localparam logic [1:0]    LAST_SLOT = 2'(FRAME_BYTES - 3);

    logic          w_byte_valid;
    logic          w_byte_err;
    logic [7:0]    w_byte;
    logic          w_par_calc;

    frame_state_t  r_state;
    logic [1:0]    r_idx;
    slots_t        r_slots;
    logic [4:0]    r_hdr_addr;
    logic          r_hdr_par;
    logic [TW-1:0] r_tmo;
    logic          r_frame_valid;
    logic          r_parity_err;
    logic          r_frame_err;
    logic [4:0]    r_addr;
    logic [1:0]    r_kind;
    logic [31:0]   r_data;

    uart_byte_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (bus.rx),
        .byte_valid (w_byte_valid),
        .byte_err   (w_byte_err),
        .byte_data  (w_byte)
    );

    assign w_par_calc      = frame_parity(r_slots, w_byte[0]);
    assign bus.frame_valid = r_frame_valid;
    assign bus.parity_err  = r_parity_err;
    assign bus.frame_err   = r_frame_err;
    assign bus.addr        = r_addr;
    assign bus.kind        = r_kind;
    assign bus.data        = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= F_IDLE;
            r_idx         <= '0;
            r_slots       <= '0;
            r_hdr_addr    <= '0;
            r_hdr_par     <= 1'b0;
            r_tmo         <= '0;
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_addr        <= '0;
            r_kind        <= '0;
            r_data        <= '0;
        end else begin
            r_frame_valid <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            if (w_byte_valid) begin
                r_tmo <= '0;
                // A header byte anywhere restarts the frame, so a lost byte costs one frame only.
                if (w_byte[7:6] == HDR) begin
                    r_frame_err <= (r_state != F_IDLE);
                    r_hdr_addr  <= w_byte[4:0];
                    r_hdr_par   <= w_byte[5];
                    r_idx       <= '0;
                    r_state     <= F_DATA;
                end else begin
                    case (r_state)
                        F_DATA: begin
                            if (w_byte[7] == DATA_MSB) begin
                                r_slots[r_idx] <= w_byte[6:0];
                                if (r_idx == LAST_SLOT) r_state <= F_TAIL;
                                else                    r_idx   <= r_idx + 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= F_IDLE;
                            end
                        end
                        F_TAIL: begin
                            r_state <= F_IDLE;
                            if (w_byte[7:6] != TAIL) begin
                                r_frame_err <= 1'b1;
                            end else if (w_par_calc == r_hdr_par) begin
                                r_frame_valid <= 1'b1;
                                r_addr        <= r_hdr_addr;
                                r_kind        <= w_byte[5:4];
                                r_data        <= assemble_data(r_slots, w_byte[3:0]);
                            end else begin
                                r_parity_err <= 1'b1;
                            end
                        end
                        default: r_state <= F_IDLE;
                    endcase
                end
            end else if (w_byte_err) begin
                r_tmo <= '0;
                if (r_state != F_IDLE) begin
                    r_frame_err <= 1'b1;
                    r_state     <= F_IDLE;
                end
            end else if (r_state != F_IDLE) begin
                if (r_tmo == TMO_LIMIT) begin
                    r_tmo       <= '0;
                    r_frame_err <= 1'b1;
                    r_state     <= F_IDLE;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end

endmodule
